// File: rtl/rgb111_pixel_serialiser_pkg.sv
// Shared constants, shifter state encoding and pixel extraction helper
// for the RGB111 pixel serialiser.
package rgb111_pixel_serialiser_pkg;

    localparam int PIX_W        = 3;
    localparam int PIX_PER_WORD = 5;
    localparam int WORD_W       = 16;
    // Bit 15 of an input word carries no pixel, so only 15 bits are stored.
    localparam int DATA_W       = PIX_W * PIX_PER_WORD;
    localparam int IDX_W        = 3;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [PIX_W-1:0] get_pixel(input logic [DATA_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx);
        logic [PIX_W-1:0] pix;
        case (idx)
            3'd0:    pix = word[2:0];
            3'd1:    pix = word[5:3];
            3'd2:    pix = word[8:6];
            3'd3:    pix = word[11:9];
            default: pix = word[14:12];
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rgb111_pixel_serialiser.sv
// Buffers 16-bit words of five packed RGB111 pixels and emits one pixel per
// pix_en strobe, with line_start resynchronisation and a sticky underrun flag.
module rgb111_pixel_serialiser #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PIX_PER_WORD = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        pix_en,
    input  logic        line_start,
    input  logic        clear_underrun,
    output logic [2:0]  rgb_111,
    output logic        pix_valid,
    output logic        underrun
);

    import rgb111_pixel_serialiser_pkg::*;

    logic [DATA_W-1:0]           head;
    logic [DATA_W-1:0]           cur_word;
    logic [DATA_W-1:0]           word_n;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        push;
    logic                        pop;
    state_t                      state;
    state_t                      state_n;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_n;
    logic [PIX_W-1:0]            pix_n;
    logic                        valid_n;
    logic                        starve;
    logic                        unused_bits;

    // Readiness looks only at stored occupancy, never at in_valid.
    assign in_ready    = ~rst & ~fifo_full;
    assign push        = in_valid & in_ready;
    assign unused_bits = ^{in_word[15], fifo_count};

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_word[DATA_W-1:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // line_start overrides the shifter; EMPTY loads regardless of pix_en.
    always_comb begin
        pop     = 1'b0;
        state_n = state;
        idx_n   = idx;
        word_n  = cur_word;
        pix_n   = '0;
        valid_n = 1'b0;
        starve  = 1'b0;
        if (line_start) begin
            idx_n = '0;
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_n = ST_ACTIVE;
                word_n  = head;
                if (pix_en) begin
                    pix_n   = get_pixel(head, '0);
                    valid_n = 1'b1;
                    idx_n   = 3'd1;
                end
            end else begin
                state_n = ST_EMPTY;
                starve  = pix_en;
            end
        end else if (state == ST_EMPTY) begin
            starve = pix_en;
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_n = ST_ACTIVE;
                word_n  = head;
                idx_n   = '0;
            end
        end else if (pix_en) begin
            pix_n   = get_pixel(cur_word, idx);
            valid_n = 1'b1;
            if (idx == IDX_W'(PIX_PER_WORD - 1)) begin
                idx_n = '0;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    word_n = head;
                end else begin
                    state_n = ST_EMPTY;
                end
            end else begin
                idx_n = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            idx       <= '0;
            cur_word  <= '0;
            rgb_111   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cur_word <= word_n;
            if (pix_en) begin
                rgb_111   <= pix_n;
                pix_valid <= valid_n;
            end
            // A new starvation event beats a simultaneous clear.
            if (starve) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb111_pixel_serialiser.sv
// Directed bench for the RGB111 pixel serialiser: hand-computed pixel
// sequences, backpressure, underrun handling, line_start and reset.
module tb_rgb111_pixel_serialiser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pix_en = 1'b0;
    logic        line_start = 1'b0;
    logic        clear_underrun = 1'b0;
    logic [2:0]  rgb_111;
    logic        pix_valid;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #6 clk = ~clk;

    rgb111_pixel_serialiser #(
        .FIFO_DEPTH   (4),
        .PIX_PER_WORD (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_word        (in_word),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pix_en         (pix_en),
        .line_start     (line_start),
        .clear_underrun (clear_underrun),
        .rgb_111        (rgb_111),
        .pix_valid      (pix_valid),
        .underrun       (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] rgb,
                             input logic valid, input logic urun);
        check({tag, "_rgb"}, 16'(rgb_111), 16'(rgb));
        check({tag, "_valid"}, 16'(pix_valid), 16'(valid));
        check({tag, "_underrun"}, 16'(underrun), 16'(urun));
    endtask

    task automatic push_word(input logic [15:0] w);
        in_word  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic strobe(input logic ls);
        pix_en     = 1'b1;
        line_start = ls;
        tick();
        pix_en     = 1'b0;
        line_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq2 [10];
        seq2 = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd0, 3'd4, 3'd6, 3'd0, 3'd1, 3'd1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_out("reset", 3'd0, 1'b0, 1'b0);
        check("reset_in_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 16'(in_ready), 16'd1);

        // All-white word: five white pixels, then output holds
        push_word(16'h7FFF);
        tick();
        for (int i = 0; i < 5; i++) begin
            strobe(1'b0);
            check_out($sformatf("white_%0d", i), 3'd7, 1'b1, 1'b0);
        end
        tick();
        check_out("white_hold", 3'd7, 1'b1, 1'b0);

        // Two words back to back, no gap pixel between them
        push_word(16'h0AC8);
        push_word(16'h1234);
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0);
            check_out($sformatf("seq_%0d", i), seq2[i], 1'b1, 1'b0);
        end

        // Fill: the shifter takes the first word, so five pushes fill the FIFO
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        check("full_in_ready", 16'(in_ready), 16'd0);
        in_word  = 16'h0006;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("full_reject_in_ready", 16'(in_ready), 16'd0);
        for (int k = 0; k < 25; k++) begin
            strobe(1'b0);
            check_out($sformatf("drain_%0d", k),
                      (k % 5 == 0) ? 3'(k / 5 + 1) : 3'd0, 1'b1, 1'b0);
            if (k == 3) check("drain_ready_lo", 16'(in_ready), 16'd0);
            if (k == 4) check("drain_ready_hi", 16'(in_ready), 16'd1);
        end

        // Underrun: set, hold, clear, and set winning over clear
        strobe(1'b0);
        check_out("underrun_set", 3'd0, 1'b0, 1'b1);
        tick();
        check_out("underrun_hold", 3'd0, 1'b0, 1'b1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("underrun_clear", 16'(underrun), 16'd0);
        clear_underrun = 1'b1;
        strobe(1'b0);
        clear_underrun = 1'b0;
        check("underrun_set_wins", 16'(underrun), 16'd1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("underrun_clear2", 16'(underrun), 16'd0);

        // line_start with pix_en skips the rest of word A
        push_word(16'h1234);
        push_word(16'h7FFF);
        strobe(1'b0);
        check_out("ls_a0", 3'd4, 1'b1, 1'b0);
        strobe(1'b0);
        check_out("ls_a1", 3'd6, 1'b1, 1'b0);
        strobe(1'b1);
        check_out("ls_b0", 3'd7, 1'b1, 1'b0);
        strobe(1'b0);
        check_out("ls_b1", 3'd7, 1'b1, 1'b0);
        strobe(1'b1);
        check_out("ls_empty", 3'd0, 1'b0, 1'b1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("ls_clear", 16'(underrun), 16'd0);

        // Reset mid-line with words buffered
        for (int i = 0; i < 4; i++) push_word(16'h7FFF);
        strobe(1'b0);
        check_out("pre_rst", 3'd7, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_in_ready_comb", 16'(in_ready), 16'd0);
        tick();
        check_out("rst_mid", 3'd0, 1'b0, 1'b0);
        check("rst_in_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 16'(in_ready), 16'd1);
        tick();
        strobe(1'b0);
        check_out("rst_flushed", 3'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
